// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: FSM states, opcodes, ALUOp codes
// and the instruction-class enum used by the decoder and trace tooling.
package legv8_ctrl_pkg;

    localparam int OPCODE_W = 11;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [OPCODE_W-1:0] OP_ADD      = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] OP_SUB      = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] OP_AND      = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OP_ORR      = 11'b10101010000;
    localparam logic [OPCODE_W-1:0] OP_LDUR     = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] OP_STUR     = 11'b11111000000;
    localparam logic [OPCODE_W-1:0] OP_CBZ_VAL  = 11'b10110100000;
    localparam logic [OPCODE_W-1:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [OPCODE_W-1:0] OP_B_VAL    = 11'b00010100000;
    localparam logic [OPCODE_W-1:0] OP_B_MASK   = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LD,
        CLS_ST,
        CLS_CBZ,
        CLS_B,
        CLS_ILL
    } instr_cls_t;

    function automatic instr_cls_t classify(input logic [OPCODE_W-1:0] op);
        instr_cls_t cls;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
            cls = CLS_R;
        else if (op == OP_LDUR)
            cls = CLS_LD;
        else if (op == OP_STUR)
            cls = CLS_ST;
        else if ((op & OP_CBZ_MASK) == OP_CBZ_VAL)
            cls = CLS_CBZ;
        else if ((op & OP_B_MASK) == OP_B_VAL)
            cls = CLS_B;
        else
            cls = CLS_ILL;
        return cls;
    endfunction

endpackage

// File: rtl/legv8_op_decode.sv
// Combinational opcode classifier; also instantiated by the disassembler/trace monitor.
module legv8_op_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_op,
    output instr_cls_t          o_cls
);

    assign o_cls = classify(i_op);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer with shared-memory handshake and a sticky wait watchdog.
// Build option: ILLEGAL_OP_TRAP_EN adds a trap output and a terminal TRAP state.
//
// state  | meaning
// FETCH  | read instruction at PC, hold until mem_ready, then PC+4 and IR capture
// DECODE | classify opcode (illegal -> NOP or TRAP)
// EXEC   | ALU op / branch resolution
// MEM    | data access at ALUOut, hold until mem_ready
// WB     | register file write from ALUOut or MDR
// TRAP   | illegal opcode seen, all controls low, wait for reset
module multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int OP_W     = 11,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            IorD,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic            ALUSrc,
    output logic [1:0]      ALUOp,
    output logic            Branch,
    output logic            UncondBranch,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic            instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic            trap,
`endif
    output logic            mem_timeout
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             r_timeout;
    instr_cls_t       w_cls;
    logic             w_unused_zero;

    // zero steers the PC source in the datapath; the sequence itself never depends on it
    assign w_unused_zero = zero;

    legv8_op_decode u_op_decode (
        .i_op  (op),
        .o_cls (w_cls)
    );

    always_comb begin
        mem_req      = 1'b0;
        IorD         = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        ALUSrc       = 1'b0;
        ALUOp        = ALUOP_ADD;
        Branch       = 1'b0;
        UncondBranch = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        MemtoReg     = 1'b0;
        instr_done   = 1'b0;
        w_next_state = r_state;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        PCWrite      = 1'b1;
                        IRWrite      = 1'b1;
                        w_next_state = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_cls == CLS_ILL) begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_next_state = ST_TRAP;
`else
                        instr_done   = 1'b1;
                        w_next_state = ST_FETCH;
`endif
                    end else begin
                        w_next_state = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_cls)
                        CLS_R: begin
                            ALUOp        = ALUOP_RTYPE;
                            w_next_state = ST_WB;
                        end
                        CLS_LD, CLS_ST: begin
                            ALUOp        = ALUOP_ADD;
                            ALUSrc       = 1'b1;
                            w_next_state = ST_MEM;
                        end
                        CLS_CBZ: begin
                            ALUOp        = ALUOP_PASSB;
                            Branch       = 1'b1;
                            instr_done   = 1'b1;
                            w_next_state = ST_FETCH;
                        end
                        CLS_B: begin
                            UncondBranch = 1'b1;
                            instr_done   = 1'b1;
                            w_next_state = ST_FETCH;
                        end
                        default: w_next_state = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemRead  = (w_cls == CLS_LD);
                    MemWrite = (w_cls == CLS_ST);
                    if (mem_ready) begin
                        if (w_cls == CLS_LD) begin
                            w_next_state = ST_WB;
                        end else begin
                            instr_done   = (w_cls == CLS_ST);
                            w_next_state = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    RegWrite     = 1'b1;
                    MemtoReg     = (w_cls == CLS_LD);
                    instr_done   = 1'b1;
                    w_next_state = ST_FETCH;
                end
                ST_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                    w_next_state = ST_TRAP;
`else
                    w_next_state = ST_FETCH;
`endif
                end
                default: w_next_state = ST_FETCH;
            endcase
        end
    end

    // Wait counter saturates; the FSM keeps waiting even after the flag sets
    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (mem_req && !mem_ready) begin
            if (r_wait_cnt != MAX_CNT)
                w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
        end else if (mem_ready || (w_next_state != r_state)) begin
            w_wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if ((MAX_WAIT != 0) && (w_wait_cnt_next == MAX_CNT))
                r_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_timeout && !reset;
`ifdef ILLEGAL_OP_TRAP_EN
    assign trap = (r_state == ST_TRAP) && !reset;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are queued
// as stimulus is driven and compared against the sampled outputs.
module tb_multicycle_control;
    import legv8_ctrl_pkg::*;

    localparam int MAX_WAIT = 4;

    localparam logic [14:0] V_REQ  = 15'h4000;
    localparam logic [14:0] V_IORD = 15'h2000;
    localparam logic [14:0] V_PCW  = 15'h1000;
    localparam logic [14:0] V_IRW  = 15'h0800;
    localparam logic [14:0] V_ASRC = 15'h0400;
    localparam logic [14:0] V_AOP1 = 15'h0200;
    localparam logic [14:0] V_AOP0 = 15'h0100;
    localparam logic [14:0] V_BR   = 15'h0080;
    localparam logic [14:0] V_UB   = 15'h0040;
    localparam logic [14:0] V_MR   = 15'h0020;
    localparam logic [14:0] V_MW   = 15'h0010;
    localparam logic [14:0] V_RW   = 15'h0008;
    localparam logic [14:0] V_M2R  = 15'h0004;
    localparam logic [14:0] V_DONE = 15'h0002;
    localparam logic [14:0] V_TO   = 15'h0001;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] op = 11'h7FF;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, IorD, PCWrite, IRWrite, ALUSrc, Branch, UncondBranch;
    logic        MemRead, MemWrite, RegWrite, MemtoReg, instr_done, mem_timeout;
    logic [1:0]  ALUOp;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        trap;
`endif
    logic [14:0] w_obs;

    int          n_vec = 0;
    int          n_err = 0;
    logic [14:0] exp_q[$];
    int          wait_cnt = 0;
    logic        exp_to = 1'b0;

    always #5 clk = ~clk;

    multicycle_control #(.OP_W(11), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .IorD         (IorD),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .ALUSrc       (ALUSrc),
        .ALUOp        (ALUOp),
        .Branch       (Branch),
        .UncondBranch (UncondBranch),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .instr_done   (instr_done),
`ifdef ILLEGAL_OP_TRAP_EN
        .trap         (trap),
`endif
        .mem_timeout  (mem_timeout)
    );

    assign w_obs = {mem_req, IorD, PCWrite, IRWrite, ALUSrc, ALUOp, Branch, UncondBranch,
                    MemRead, MemWrite, RegWrite, MemtoReg, instr_done, mem_timeout};

    task automatic check_vec(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; drives mem_ready, queues the expectation, samples, steps one clock
    task automatic cycle(input string tag, input logic ready, input logic [14:0] exp);
        logic [14:0] e;
        mem_ready = ready;
        e = exp;
        if (!reset) begin
            if (MAX_WAIT != 0 && wait_cnt == MAX_WAIT)
                exp_to = 1'b1;
            e = exp | (exp_to ? V_TO : 15'd0);
        end
        exp_q.push_back(e);
        #2;
        check_vec(tag, w_obs, exp_q.pop_front());
        if (!reset && (exp & V_REQ) != 0) begin
            if (!ready) begin
                if (wait_cnt < MAX_WAIT) wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++)
            cycle("reset", 1'b1, 15'd0);
        reset    = 1'b0;
        wait_cnt = 0;
        exp_to   = 1'b0;
    endtask

    task automatic do_instr(input string name, input logic [10:0] op_v, input logic zero_v,
                            input int kind, input int fw, input int mw);
        op   = 11'h7FF;
        zero = zero_v;
        for (int i = 0; i < fw; i++)
            cycle({name, "_fetch_wait"}, 1'b0, V_REQ | V_MR);
        cycle({name, "_fetch"}, 1'b1, V_REQ | V_MR | V_PCW | V_IRW);
        op = op_v;
        if (kind == K_ILL) begin
`ifdef ILLEGAL_OP_TRAP_EN
            cycle({name, "_decode_trap"}, 1'b1, 15'd0);
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1;
                #2;
                check_vec({name, "_trap_outs"}, w_obs, 15'd0);
                check_vec({name, "_trap_flag"}, 15'(trap), 15'd1);
                @(posedge clk);
                #1;
            end
`else
            cycle({name, "_decode_nop"}, 1'b1, V_DONE);
`endif
            return;
        end
        cycle({name, "_decode"}, 1'b1, 15'd0);
        case (kind)
            K_R:   cycle({name, "_exec"}, 1'b1, V_AOP1);
            K_LD,
            K_ST:  cycle({name, "_exec"}, 1'b1, V_ASRC);
            K_CBZ: cycle({name, "_exec"}, 1'b1, V_AOP0 | V_BR | V_DONE);
            default: cycle({name, "_exec"}, 1'b1, V_UB | V_DONE);
        endcase
        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i < mw; i++)
                cycle({name, "_mem_wait"}, 1'b0,
                      V_REQ | V_IORD | ((kind == K_LD) ? V_MR : V_MW));
            if (kind == K_LD)
                cycle({name, "_mem"}, 1'b1, V_REQ | V_IORD | V_MR);
            else
                cycle({name, "_mem"}, 1'b1, V_REQ | V_IORD | V_MW | V_DONE);
        end
        if (kind == K_R)
            cycle({name, "_wb"}, 1'b1, V_RW | V_DONE);
        else if (kind == K_LD)
            cycle({name, "_wb"}, 1'b1, V_RW | V_M2R | V_DONE);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);
        do_instr("add", 11'b10001011000, 1'b0, K_R, 0, 0);
        do_instr("ldur", 11'b11111000010, 1'b0, K_LD, 0, 2);
        do_instr("cbz_z1", 11'b10110100101, 1'b1, K_CBZ, 0, 0);
        do_instr("cbz_z0", 11'b10110100010, 1'b0, K_CBZ, 0, 0);
        do_instr("stur", 11'b11111000000, 1'b0, K_ST, 0, 0);
        do_instr("b", 11'b00010111011, 1'b0, K_B, 0, 0);
        do_instr("sub", 11'b11001011000, 1'b0, K_R, 0, 0);
        do_instr("and", 11'b10001010000, 1'b0, K_R, 1, 0);
        do_instr("orr", 11'b10101010000, 1'b0, K_R, 0, 0);
        do_instr("ldur0", 11'b11111000010, 1'b0, K_LD, 0, 0);

        // reset while ADD sits in EXEC: no writeback may follow
        op = 11'h7FF;
        cycle("mid_fetch", 1'b1, V_REQ | V_MR | V_PCW | V_IRW);
        op = 11'b10001011000;
        cycle("mid_decode", 1'b1, 15'd0);
        reset = 1'b1;
        cycle("mid_reset", 1'b1, 15'd0);
        reset    = 1'b0;
        wait_cnt = 0;
        exp_to   = 1'b0;
        do_instr("post_rst", 11'b11111000000, 1'b0, K_ST, 0, 0);

        do_instr("illegal", 11'h7FF, 1'b0, K_ILL, 0, 0);
`ifdef ILLEGAL_OP_TRAP_EN
        do_reset(2);
`endif
        do_instr("after_ill", 11'b10001011000, 1'b0, K_R, 0, 0);

        do_reset(2);
        do_instr("wdog", 11'b00010100000, 1'b0, K_B, 6, 0);
        do_instr("wdog_sticky", 11'b10001011000, 1'b0, K_R, 0, 0);
        do_reset(1);
        do_instr("wdog_clr", 11'b00010100000, 1'b0, K_B, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
